clint_vectored: RTL and testbench
=================================

CLINT_VECTORED -- requirements
Module: clint_vectored

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of asynchronous interrupt lines, legal range 1..16.
REQ-002 Parameter ID_W, default 4, width of the claim ID; SHALL satisfy 2^ID_W >= NUM_IRQ.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 irq_i  in  NUM_IRQ  level interrupt requests.
REQ-006 irq_en_i  in  NUM_IRQ  per-line enables (mie image).
REQ-007 global_int_en_i  in  1  mstatus.MIE.
REQ-008 inst_i, inst_addr_i  in  32 each  instruction in decode and its address.
REQ-009 jump_flag_i  in  1; jump_addr_i  in  32; div_started_i  in  1  execute-stage status.
REQ-010 csr_mtvec, csr_mepc, csr_mstatus  in  32 each  current CSR values.
REQ-011 hold_flag_o  out  1  pipeline hold request.
REQ-012 we_o  out  1; waddr_o  out  32; data_o  out  32  CSR write port.
REQ-013 int_assert_o  out  1; int_addr_o  out  32  redirect pulse and target to execute.
REQ-014 pending_o  out  NUM_IRQ  registered irq_i & irq_en_i (mip image).
REQ-015 claim_id_o  out  ID_W  index of the last taken asynchronous interrupt.

Function
REQ-016 pending_o SHALL update every cycle to irq_i & irq_en_i, giving one cycle of latency.
REQ-017 Arbitration: the lowest-index set bit of pending_o wins; an asynchronous request exists only when pending_o != 0 and global_int_en_i = 1.
REQ-018 Request priority in IDLE: ECALL/EBREAK > asynchronous > MRET.
REQ-019 ECALL/EBREAK while div_started_i = 1 SHALL be deferred; no entry, FSM stays IDLE.
REQ-020 FSM states: IDLE, MEPC, MSTATUS, MCAUSE, MRET. Sequences are IDLE->MEPC->MSTATUS->MCAUSE->IDLE and IDLE->MRET->IDLE.
REQ-021 On leaving IDLE for entry, mepc value and cause SHALL be latched. Later irq changes do not alter an in-flight sequence.
REQ-022 Sync mepc: jump_addr_i-4 if jump_flag_i, else inst_addr_i. Sync cause: ECALL 11, EBREAK 3.
REQ-023 Async mepc: jump_addr_i if jump_flag_i; else inst_addr_i-4 if div_started_i; else inst_addr_i.
REQ-024 Async cause SHALL be 0x80000000 | (16 + id); claim_id_o <= id at the same edge.
REQ-025 Register writes, one cycle each after the state is entered: MEPC to 0x341 = latched pc; MSTATUS to 0x300 with MPIE<=MIE and MIE<=0, other bits kept; MCAUSE to 0x342 = cause.
REQ-026 int_assert_o SHALL pulse for one cycle, coincident with the mcause write, carrying int_addr_o = target.
REQ-027 MRET: one cycle of we_o to 0x300 with MIE<=MPIE and MPIE<=1, coincident with int_assert_o = 1 and int_addr_o = csr_mepc.
REQ-028 When not writing: we_o=0, waddr_o=0, data_o=0. When not asserting: int_assert_o=0, int_addr_o=0.
REQ-029 hold_flag_o = 1 whenever the FSM is not IDLE or an IDLE request is taken this cycle (combinational).
REQ-030 Entry latency SHALL be fixed: request accepted at edge E0; mepc write after E1; mstatus after E2; mcause and int_assert after E3.
REQ-031 A request arriving during a sequence SHALL be evaluated only after the FSM returns to IDLE.

Reset
REQ-032 With rst=1 at an edge: FSM->IDLE; all outputs, pending_o, claim_id_o and the latched pc/cause ->0. An in-progress sequence is abandoned with no further writes.

Configuration
REQ-033 Macro CLINT_VECTORED_MODE_EN defined: an async target with csr_mtvec[1:0]=01 SHALL be {csr_mtvec[31:2],2'b00} + 4*cause[30:0]; sync traps and mode 00 use {csr_mtvec[31:2],2'b00}.
REQ-034 Macro undefined: every target SHALL be {csr_mtvec[31:2],2'b00}, and mode bits are ignored.

Verification
REQ-035 irq_i[5]=irq_i[2]=1, enables all 1, MIE=1, mtvec=0x100 -> claim_id_o=2; mcause=0x80000012; mepc=inst_addr_i; int_assert at E3 with int_addr_o=0x100.
REQ-036 Same as REQ-035 with CLINT_VECTORED_MODE_EN and mtvec=0x101 -> int_addr_o=0x148.
REQ-037 ECALL at pc 0x80 with irq pending -> mcause=11, mepc=0x80; async taken only after return to IDLE.
REQ-038 irq_i[3]=1 with irq_en_i[3]=0, or with global_int_en_i=0 -> no writes, hold_flag_o=0, pending_o reflects only enabled lines.
REQ-039 MRET with mstatus=0x80, mepc=0x200 -> one write of mstatus=0x88, int_addr_o=0x200, int_assert 1 cycle.
REQ-040 rst asserted in MSTATUS state -> next cycle we_o=0, int_assert_o=0, FSM IDLE, no mcause write.

Source files
------------

// File: rtl/clint_vectored.sv
// clint_vectored -- core-local interrupt controller with trap-entry sequencer.
//
// Registers the enabled interrupt lines into a mip-style pending image.
// The controller arbitrates between synchronous traps (ECALL/EBREAK),
// asynchronous interrupts and MRET, then sequences the CSR writes
// (mepc, mstatus, mcause) needed to enter or leave a trap.
//
// Optional feature: define CLINT_VECTORED_MODE_EN to honour mtvec vectored
// mode (mtvec[1:0] = 01) for asynchronous interrupts. With the macro
// undefined, every trap goes to the mtvec base and the mode bits are ignored.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   irq_i, irq_en_i     level interrupt requests and per-line enables
//   global_int_en_i     mstatus.MIE
//   inst_i, inst_addr_i instruction in decode and its address
//   jump_flag_i, jump_addr_i, div_started_i   execute-stage status
//   csr_mtvec, csr_mepc, csr_mstatus          current CSR values
//   hold_flag_o         pipeline hold (combinational)
//   we_o, waddr_o, data_o                     CSR write port (registered)
//   int_assert_o, int_addr_o                  redirect pulse and target
//   pending_o           registered irq_i & irq_en_i
//   claim_id_o          index of the last taken asynchronous interrupt
//
// ID_W must satisfy 2**ID_W >= NUM_IRQ; NUM_IRQ is limited to 1..16.

module clint_vectored #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic               global_int_en_i,
    input  logic [31:0]        inst_i,
    input  logic [31:0]        inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [31:0]        jump_addr_i,
    input  logic               div_started_i,
    input  logic [31:0]        csr_mtvec,
    input  logic [31:0]        csr_mepc,
    input  logic [31:0]        csr_mstatus,
    output logic               hold_flag_o,
    output logic               we_o,
    output logic [31:0]        waddr_o,
    output logic [31:0]        data_o,
    output logic               int_assert_o,
    output logic [31:0]        int_addr_o,
    output logic [NUM_IRQ-1:0] pending_o,
    output logic [ID_W-1:0]    claim_id_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [31:0] CSR_MSTATUS = 32'h300;
    localparam logic [31:0] CSR_MEPC    = 32'h341;
    localparam logic [31:0] CSR_MCAUSE  = 32'h342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEPC,
        S_MSTATUS,
        S_MCAUSE,
        S_MRET
    } state_t;

    state_t state, state_nxt;

    logic [31:0]     lat_pc, lat_cause;
    logic            is_sync, is_mret, async_req;
    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic            take_sync, take_async, take_mret;
    logic [31:0]     entry_pc, entry_cause, target;
    logic            we_nxt, ia_nxt;
    logic [31:0]     waddr_nxt, data_nxt, iaddr_nxt;
    logic [31:0]     mstatus_entry, mstatus_mret;

    assign is_sync   = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
    assign is_mret   = (inst_i == INST_MRET);
    assign async_req = (pending_o != '0) && global_int_en_i;

    // Lowest-index pending line wins: scan downwards so the last hit is lowest.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_o[i]) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
            end
        end
    end

    // mepc/cause for whichever entry is taken this cycle.
    always_comb begin
        if (is_sync) begin
            entry_pc    = jump_flag_i ? (jump_addr_i - 32'd4) : inst_addr_i;
            entry_cause = (inst_i == INST_ECALL) ? 32'd11 : 32'd3;
        end else begin
            // Async trap lands between instructions: a taken jump has not
            // executed its target yet, a running divide must be replayed.
            if (jump_flag_i)
                entry_pc = jump_addr_i;
            else if (div_started_i)
                entry_pc = inst_addr_i - 32'd4;
            else
                entry_pc = inst_addr_i;
            entry_cause = 32'h8000_0000 | (32'd16 + 32'(win_id));
        end
    end

    // Trap target, computed from the latched cause while in S_MCAUSE.
`ifdef CLINT_VECTORED_MODE_EN
    always_comb begin
        target = {csr_mtvec[31:2], 2'b00};
        if (lat_cause[31] && (csr_mtvec[1:0] == 2'b01))
            target = {csr_mtvec[31:2], 2'b00} + {lat_cause[29:0], 2'b00};
    end
`else
    logic unused_mode;
    assign unused_mode = ^{csr_mtvec[1:0], win_found};
    assign target      = {csr_mtvec[31:2], 2'b00};
`endif

    // Entry: MPIE <= MIE, MIE <= 0. Return: MIE <= MPIE, MPIE <= 1.
    assign mstatus_entry = {csr_mstatus[31:8], csr_mstatus[3], csr_mstatus[6:4], 1'b0, csr_mstatus[2:0]};
    assign mstatus_mret  = {csr_mstatus[31:8], 1'b1, csr_mstatus[6:4], csr_mstatus[7], csr_mstatus[2:0]};

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        take_sync  = 1'b0;
        take_async = 1'b0;
        take_mret  = 1'b0;
        we_nxt     = 1'b0;
        waddr_nxt  = '0;
        data_nxt   = '0;
        ia_nxt     = 1'b0;
        iaddr_nxt  = '0;
        case (state)
            S_IDLE: begin
                // A deferred ECALL/EBREAK blocks everything until the divide ends.
                if (is_sync) begin
                    if (!div_started_i) begin
                        take_sync = 1'b1;
                        state_nxt = S_MEPC;
                    end
                end else if (async_req) begin
                    take_async = 1'b1;
                    state_nxt  = S_MEPC;
                end else if (is_mret) begin
                    take_mret = 1'b1;
                    state_nxt = S_MRET;
                end
            end
            S_MEPC: begin
                we_nxt    = 1'b1;
                waddr_nxt = CSR_MEPC;
                data_nxt  = lat_pc;
                state_nxt = S_MSTATUS;
            end
            S_MSTATUS: begin
                we_nxt    = 1'b1;
                waddr_nxt = CSR_MSTATUS;
                data_nxt  = mstatus_entry;
                state_nxt = S_MCAUSE;
            end
            S_MCAUSE: begin
                we_nxt    = 1'b1;
                waddr_nxt = CSR_MCAUSE;
                data_nxt  = lat_cause;
                ia_nxt    = 1'b1;
                iaddr_nxt = target;
                state_nxt = S_IDLE;
            end
            S_MRET: begin
                we_nxt    = 1'b1;
                waddr_nxt = CSR_MSTATUS;
                data_nxt  = mstatus_mret;
                ia_nxt    = 1'b1;
                iaddr_nxt = csr_mepc;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign hold_flag_o = (state != S_IDLE) || take_sync || take_async || take_mret;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_o    <= '0;
            claim_id_o   <= '0;
            lat_pc       <= '0;
            lat_cause    <= '0;
            we_o         <= 1'b0;
            waddr_o      <= '0;
            data_o       <= '0;
            int_assert_o <= 1'b0;
            int_addr_o   <= '0;
        end else begin
            pending_o    <= irq_i & irq_en_i;
            we_o         <= we_nxt;
            waddr_o      <= waddr_nxt;
            data_o       <= data_nxt;
            int_assert_o <= ia_nxt;
            int_addr_o   <= iaddr_nxt;
            if (take_sync || take_async) begin
                lat_pc    <= entry_pc;
                lat_cause <= entry_cause;
            end
            if (take_async)
                claim_id_o <= win_id;
        end
    end

endmodule

// File: tb/tb_clint_vectored.sv
// tb_clint_vectored -- randomized self-checking bench for clint_vectored.
// A transaction-level model (a queue of scheduled CSR-write slots) predicts
// every registered output; a compare process checks it each cycle, and
// directed scenarios pin literal values.

module tb_clint_vectored;
    localparam int N  = 8;
    localparam int IW = 4;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq, en;
    logic          gie;
    logic [31:0]   inst, iaddr, jaddr, mtvec, mepc, mstatus;
    logic          jump, div;
    logic          hold, we, ia;
    logic [31:0]   waddr, wdata, iaddr_o;
    logic [N-1:0]  pend;
    logic [IW-1:0] claim;

    always #5 clk = ~clk;

    clint_vectored #(.NUM_IRQ(N), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .irq_i(irq), .irq_en_i(en), .global_int_en_i(gie),
        .inst_i(inst), .inst_addr_i(iaddr), .jump_flag_i(jump), .jump_addr_i(jaddr),
        .div_started_i(div), .csr_mtvec(mtvec), .csr_mepc(mepc), .csr_mstatus(mstatus),
        .hold_flag_o(hold), .we_o(we), .waddr_o(waddr), .data_o(wdata),
        .int_assert_o(ia), .int_addr_o(iaddr_o), .pending_o(pend), .claim_id_o(claim)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {K_MEPC, K_MSTATUS, K_MCAUSE, K_MRET} kind_t;
    kind_t         sched[$];       // one entry per upcoming edge of a busy sequence
    logic [N-1:0]  m_pend;
    logic [IW-1:0] m_claim;
    logic [31:0]   m_pc, m_cause;
    logic          e_we, e_ia;
    logic [31:0]   e_waddr, e_data, e_iaddr;
    bit            model_on = 0;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    // 0 none, 1 sync trap, 2 async interrupt, 3 mret
    function automatic int decide();
        if (inst == ECALL || inst == EBREAK) return div ? 0 : 1;
        if (m_pend != 0 && gie) return 2;
        if (inst == MRET) return 3;
        return 0;
    endfunction

    function automatic logic [31:0] trap_target();
        logic [31:0] base;
        base = mtvec & 32'hFFFF_FFFC;
`ifdef CLINT_VECTORED_MODE_EN
        if (m_cause[31] && mtvec[1:0] == 2'b01)
            return base + 32'd4 * (m_cause & 32'h7FFF_FFFF);
`endif
        return base;
    endfunction

    initial begin
        int d, id;
        kind_t k;
        forever begin
            @(posedge clk);
            e_we = 0; e_waddr = 0; e_data = 0; e_ia = 0; e_iaddr = 0;
            if (rst) begin
                sched.delete();
                m_pend = 0; m_claim = 0; m_pc = 0; m_cause = 0;
            end else begin
                d = (sched.size() == 0) ? decide() : 0;
                if (sched.size() != 0) begin
                    k = sched.pop_front();
                    e_we = 1;
                    case (k)
                        K_MEPC:    begin e_waddr = 32'h341; e_data = m_pc; end
                        K_MSTATUS: begin
                            e_waddr = 32'h300;
                            e_data  = (mstatus & ~32'h88) | (mstatus[3] ? 32'h80 : 32'h0);
                        end
                        K_MCAUSE:  begin
                            e_waddr = 32'h342; e_data = m_cause;
                            e_ia = 1; e_iaddr = trap_target();
                        end
                        default:   begin
                            e_waddr = 32'h300;
                            e_data  = (mstatus & ~32'h8) | 32'h80 | (mstatus[7] ? 32'h8 : 32'h0);
                            e_ia = 1; e_iaddr = mepc;
                        end
                    endcase
                end
                if (d == 1) begin
                    m_pc    = jump ? jaddr - 4 : iaddr;
                    m_cause = (inst == ECALL) ? 11 : 3;
                end else if (d == 2) begin
                    id      = lowest(m_pend);
                    m_claim = IW'(id);
                    m_pc    = jump ? jaddr : (div ? iaddr - 4 : iaddr);
                    m_cause = 32'h8000_0000 + 32'(16 + id);
                end
                if (d == 1 || d == 2) begin
                    sched.push_back(K_MEPC); sched.push_back(K_MSTATUS); sched.push_back(K_MCAUSE);
                end else if (d == 3) begin
                    sched.push_back(K_MRET);
                end
                m_pend = irq & en;
            end
        end
    end

    // compare process: registered outputs and combinational hold, every cycle
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("we", {31'b0, we}, {31'b0, e_we});
                chk("waddr", waddr, e_waddr);
                chk("data", wdata, e_data);
                chk("int_assert", {31'b0, ia}, {31'b0, e_ia});
                chk("int_addr", iaddr_o, e_iaddr);
                chk("pending", 32'(pend), 32'(m_pend));
                chk("claim_id", 32'(claim), 32'(m_claim));
                chk("hold", {31'b0, hold}, (sched.size() != 0 || decide() != 0) ? 32'd1 : 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_idle();
        irq = 0; en = '1; gie = 1; inst = NOP; iaddr = 32'h40; jaddr = 0;
        jump = 0; div = 0; mtvec = 32'h101; mepc = 0; mstatus = 32'h8;
    endtask

    task automatic drain();
        irq = 0; inst = NOP;
        repeat (6) @(negedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] c1, c2, m1, x_iaddr, x_data, x_waddr;
        logic [IW-1:0] x_claim;
        int n1, n2, wcnt, iacnt, hcnt, idx1, idx2;
        bit found;

        rst = 1; set_idle();
        repeat (3) @(negedge clk);
        #1; rst = 0; model_on = 1;

        // pending line 5 and 2, vectored mtvec: line 2 wins
        set_idle(); irq = 8'h24; n1 = 0; idx1 = -1; m1 = 0; c1 = 0; x_iaddr = 0; x_claim = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (n1 == 0 && we && waddr == 32'h341) m1 = wdata;
            if (n1 == 0 && we && waddr == 32'h342) begin
                c1 = wdata; x_iaddr = iaddr_o; x_claim = claim; idx1 = c; n1 = 1;
            end
            #1;
        end
        chk("a_claim", 32'(x_claim), 32'd2);
        chk("a_mepc", m1, 32'h40);
        chk("a_mcause", c1, 32'h8000_0012);
        chk("a_latency", 32'(idx1), 32'd4);
`ifdef CLINT_VECTORED_MODE_EN
        chk("a_target", x_iaddr, 32'h148);
`else
        chk("a_target", x_iaddr, 32'h100);
`endif
        drain();

        // ECALL with an irq pending: sync first, async after returning to idle
        set_idle(); irq = 8'h01; inst = ECALL; iaddr = 32'h80;
        n1 = 0; idx1 = -1; idx2 = -1; c1 = 0; c2 = 0; m1 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (n1 == 0 && we && waddr == 32'h341) m1 = wdata;
            if (we && waddr == 32'h342) begin
                if (n1 == 0) begin c1 = wdata; idx1 = c; end
                else if (n1 == 1) begin c2 = wdata; idx2 = c; end
                n1++;
            end
            #1;
            if (c == 0) inst = NOP;
        end
        chk("b_mcause", c1, 32'd11);
        chk("b_mepc", m1, 32'h80);
        chk("b_async_cause", c2, 32'h8000_0010);
        chk("b_async_after", 32'(idx2 - idx1), 32'd4);
        drain();

        // MRET: single mstatus write with MIE <= MPIE
        set_idle(); mstatus = 32'h80; mepc = 32'h200; inst = MRET;
        wcnt = 0; iacnt = 0; x_data = 0; x_waddr = 0; x_iaddr = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (we) begin wcnt++; x_data = wdata; x_waddr = waddr; end
            if (ia) begin iacnt++; x_iaddr = iaddr_o; end
            #1;
            if (c == 0) inst = NOP;
        end
        chk("c_writes", 32'(wcnt), 32'd1);
        chk("c_mstatus", x_data, 32'h88);
        chk("c_waddr", x_waddr, 32'h300);
        chk("c_int_addr", x_iaddr, 32'h200);
        chk("c_pulses", 32'(iacnt), 32'd1);
        drain();

        // masked line, then globally disabled
        set_idle(); irq = 8'h08; en = 8'hF7; wcnt = 0; hcnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); wcnt += int'(we); hcnt += int'(hold); #1;
        end
        chk("d_pend_masked", 32'(pend), 32'h0);
        en = 8'hFF; gie = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); wcnt += int'(we); hcnt += int'(hold); #1;
        end
        chk("d_pend_enabled", 32'(pend), 32'h08);
        chk("d_writes", 32'(wcnt), 32'd0);
        chk("d_hold", 32'(hcnt), 32'd0);
        drain();

        // reset while in the mstatus step abandons the sequence
        set_idle(); irq = 8'h10; found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (we && waddr == 32'h341) found = 1;
            #1;
        end
        chk("e_reached_mstatus", {31'b0, found}, 32'd1);
        rst = 1;
        @(negedge clk);
        chk("e_we", {31'b0, we}, 32'd0);
        chk("e_int_assert", {31'b0, ia}, 32'd0);
        chk("e_hold", {31'b0, hold}, 32'd0);
        #1; rst = 0; irq = 0; n2 = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); if (we) n2++; #1;
        end
        chk("e_no_writes", 32'(n2), 32'd0);

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 15);
            inst    = (r == 0) ? ECALL : (r == 1) ? EBREAK : (r < 4) ? MRET : $urandom;
            irq     = (N)'($urandom_range(0, 3) == 0 ? $urandom : 0);
            en      = (N)'($urandom);
            gie     = ($urandom_range(0, 3) != 0);
            jump    = ($urandom_range(0, 3) == 0);
            div     = ($urandom_range(0, 3) == 0);
            iaddr   = $urandom & 32'hFFFF_FFFC;
            jaddr   = $urandom & 32'hFFFF_FFFC;
            mtvec   = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFD) | 32'h1 : $urandom;
            mepc    = $urandom;
            mstatus = $urandom;
            rst     = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            #1;
        end
        rst = 0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
